// File: rtl/boreal_frame_sequencer.sv
// Multi-channel frame assembler: gathers NUM_CH in-order samples into one
// frame and tags it with an ID, a ms timestamp and the safety tier. It also
// generates the 1 kHz system tick and recovers from out-of-order samples and
// stalled partial frames.
//
// state | meaning
// IDLE  | no partial frame, waiting for a channel-0 sample
// FILL  | partial frame open, expecting channel exp_ch (1..NUM_CH-1)
module boreal_frame_sequencer #(
    parameter int NUM_CH        = 8,
    parameter int SAMPLE_W      = 24,
    parameter int FID_W         = 8,
    parameter int TICK_DIV      = 100000,
    parameter int TIMEOUT_TICKS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_valid,
    input  logic [$clog2(NUM_CH)-1:0]     s_ch,
    input  logic [SAMPLE_W-1:0]           s_data,
    input  logic [1:0]                    safety_tier,
    output logic [NUM_CH*SAMPLE_W-1:0]    m_frame,
    output logic [FID_W-1:0]              m_frame_id,
    output logic [15:0]                   m_timestamp,
    output logic [1:0]                    m_tier,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          tick_1khz,
    output logic [15:0]                   drop_cnt,
    output logic                          seq_err
);

    localparam int CH_W = $clog2(NUM_CH);
    localparam int TK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    state_t                       state;
    logic [CH_W-1:0]              exp_ch;
    logic [NUM_CH*SAMPLE_W-1:0]   asm_buf;
    logic [NUM_CH*SAMPLE_W-1:0]   frame_next;
    logic [15:0]                  ts_buf;
    logic [FID_W-1:0]             fid_cnt;
    logic [TO_W-1:0]              to_cnt;
    logic [TK_W-1:0]              tick_cnt;
    logic [15:0]                  ms_cnt;

    logic tick_hit;
    logic accept;
    logic complete;
    logic out_free;
    logic timeout_hit;

    assign tick_hit    = (tick_cnt == TK_W'(TICK_DIV - 1));
    assign tick_1khz   = tick_hit;
    assign accept      = s_valid && (s_ch == exp_ch);
    assign complete    = accept && (state == FILL) && (s_ch == LAST_CH);
    assign out_free    = !m_valid || m_ready;
    assign timeout_hit = (state == FILL) && tick_hit &&
                         (to_cnt == TO_W'(TIMEOUT_TICKS - 1));

    // Assembly buffer with the incoming sample merged into its lane.
    always_comb begin
        frame_next = asm_buf;
        frame_next[int'(s_ch)*SAMPLE_W +: SAMPLE_W] = s_data;
    end

    // Free-running tick divider and wrapping millisecond counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
            ms_cnt   <= '0;
        end else if (tick_hit) begin
            tick_cnt <= '0;
            ms_cnt   <= ms_cnt + 16'd1;
        end else begin
            tick_cnt <= tick_cnt + TK_W'(1);
        end
    end

    // Frame sequencing, timeout recovery and output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            exp_ch      <= '0;
            asm_buf     <= '0;
            ts_buf      <= '0;
            fid_cnt     <= '0;
            to_cnt      <= '0;
            m_frame     <= '0;
            m_frame_id  <= '0;
            m_timestamp <= '0;
            m_tier      <= '0;
            m_valid     <= 1'b0;
            drop_cnt    <= '0;
            seq_err     <= 1'b0;
        end else begin
            seq_err <= 1'b0;
            if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    // Only channel 0 can open a frame; anything else is ignored.
                    if (accept) begin
                        asm_buf <= frame_next;
                        ts_buf  <= ms_cnt;
                        exp_ch  <= CH_W'(1);
                        to_cnt  <= '0;
                        state   <= FILL;
                    end
                end

                FILL: begin
                    if (accept) begin
                        // An accepted sample beats a coincident timeout.
                        asm_buf <= frame_next;
                        to_cnt  <= '0;
                        if (complete) begin
                            if (out_free) begin
                                m_frame     <= frame_next;
                                m_frame_id  <= fid_cnt;
                                m_timestamp <= ts_buf;
                                m_tier      <= safety_tier;
                                m_valid     <= 1'b1;
                            end else if (drop_cnt != 16'hFFFF) begin
                                drop_cnt <= drop_cnt + 16'd1;
                            end
                            // IDs advance on drops too so downstream sees the gap.
                            fid_cnt <= fid_cnt + FID_W'(1);
                            exp_ch  <= '0;
                            state   <= IDLE;
                        end else begin
                            exp_ch <= exp_ch + CH_W'(1);
                        end
                    end else if (s_valid) begin
                        // Out-of-order sample; also covers a coincident timeout.
                        seq_err <= 1'b1;
                        to_cnt  <= '0;
                        if (s_ch == '0) begin
                            asm_buf <= frame_next;
                            ts_buf  <= ms_cnt;
                            exp_ch  <= CH_W'(1);
                        end else begin
                            exp_ch <= '0;
                            state  <= IDLE;
                        end
                    end else if (timeout_hit) begin
                        seq_err <= 1'b1;
                        to_cnt  <= '0;
                        exp_ch  <= '0;
                        state   <= IDLE;
                    end else if (tick_hit) begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end

                default: begin
                    exp_ch <= '0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/boreal_frame_sequencer.md
Name: boreal_frame_sequencer

Overview:
Parametrised multi-channel frame assembler between the ADC SPI front end and the per-frame feature chain (normaliser, spatial filter, HID report). It collects NUM_CH per-channel samples into one frame. Each frame is tagged with a frame ID, a millisecond timestamp and the safety tier, and leaves through a valid/ready output register. It replaces ad-hoc "ch == last" frame strobes with explicit sequence checking, timeout recovery and overflow drop accounting, and it also generates the 1 kHz system tick.

Parameters:
NUM_CH, 8, channels per frame (2..16)
SAMPLE_W, 24, bits per channel sample
FID_W, 8, frame ID width
TICK_DIV, 100000, clk cycles per tick_1khz pulse
TIMEOUT_TICKS, 4, ticks allowed between samples of one partial frame before it is discarded

Ports:
clk  in  1  system clock; the only clock
rst  in  1  asynchronous active-high reset
s_valid  in  1  one-cycle strobe: s_ch/s_data valid
s_ch  in  $clog2(NUM_CH)  channel index of the sample
s_data  in  SAMPLE_W  signed sample
safety_tier  in  2  current safety tier
m_frame  out  NUM_CH*SAMPLE_W  frame; channel k occupies bits [k*SAMPLE_W +: SAMPLE_W]
m_frame_id  out  FID_W  frame sequence number
m_timestamp  out  16  ms count captured at the channel-0 sample
m_tier  out  2  safety_tier sampled at frame completion
m_valid  out  1  output frame valid
m_ready  in  1  downstream accepts the frame
tick_1khz  out  1  one-cycle pulse every TICK_DIV cycles
drop_cnt  out  16  frames lost to backpressure, saturating
seq_err  out  1  one-cycle pulse when a partial frame is discarded

Behaviour:
- Reset (asynchronous, any time, including mid-frame): every output is 0. The partial frame, expected channel, tick counter, ms counter, timeout counter and frame ID counter all clear. The next frame emitted carries ID 0.
- Tick: the counter runs 0..TICK_DIV-1. tick_1khz is high in the cycle the counter equals TICK_DIV-1. The ms counter increments on that cycle and wraps at 0xFFFF -> 0.
- State machine:
  - IDLE: waits for a sample on channel 0.
  - FILL: expecting channel exp_ch, 1..NUM_CH-1.
- Accepted sample (s_valid and s_ch == exp_ch):
  - Write the sample into lane s_ch of the assembly buffer and increment exp_ch.
  - If it is channel 0, capture the ms counter into the timestamp and go to FILL.
  - The timeout counter clears on every accepted sample.
- Out-of-order sample, in FILL:
  - Discard the partial frame and pulse seq_err.
  - If s_ch == 0, start a new frame with this sample (go to FILL, exp_ch = 1).
  - Otherwise go to IDLE.
- Out-of-order sample, in IDLE: a nonzero s_ch is ignored silently, with no seq_err.
- Timeout, in FILL: each tick_1khz increments the timeout counter. When it reaches TIMEOUT_TICKS:
  - Discard the partial frame, pulse seq_err and go to IDLE.
  - If a sample is accepted in the same cycle, the sample wins and the counter clears.
- Completion: accepting channel NUM_CH-1 completes the frame.
  - The output register is free if m_valid == 0, or m_valid && m_ready in that same cycle.
  - If free: load m_frame, m_frame_id, m_timestamp and m_tier (= safety_tier) on that edge. m_valid rises in the next cycle, a latency of 1 cycle after the last sample.
  - If not free: drop the frame and increment drop_cnt, saturating at 0xFFFF.
  - In both cases the frame ID counter increments, wrapping at 2^FID_W, so downstream sees gaps on drops.
  - Return to IDLE.
- Output handshake: m_valid holds, with its data stable, until m_valid && m_ready. With no new frame loading, m_valid falls on the next cycle. The output register is a single stage.
- seq_err and tick_1khz are single-cycle pulses. Simultaneous seq_err sources collapse to one pulse.

Test Plan:
- NUM_CH=8, samples ch0..ch7 with data 0x000010*k, m_ready=1 -> m_valid one cycle after ch7; lane k = 0x000010*k; m_frame_id=0; next frame id=1.
- Sequence ch0,ch1,ch2,ch5 -> seq_err pulse on the ch5 cycle, state IDLE, no m_valid. Following ch0..ch7 -> frame with id 0.
- m_ready=0, three complete frames -> frame 0 held stable; drop_cnt=2. After m_ready=1 and a fourth frame -> m_frame_id=3.
- TICK_DIV=10, TIMEOUT_TICKS=4, send ch0..ch3 then idle 40 cycles -> seq_err on the 4th tick; the next ch0..ch7 produces a valid frame.
- Assert rst mid-frame after ch4 -> all outputs 0 immediately (asynchronously). A full frame after release -> id 0, timestamp 0 if sent before the first tick.
- safety_tier=2 at ch7 acceptance -> m_tier=2. Frame ID counter with FID_W=2 wraps 3->0 on the fifth frame.
